// File: rtl/window_dispatcher_if.sv
// Window dispatcher bus.
// Carries the serial pixel input handshake, the issued-window output
// (data, destination select, valid, last), the per-destination ready vector
// and the transferred-window counter.
//   master : the dispatcher side (accepts pixels, issues windows)
//   slave  : the pixel source plus the destination fabric
interface window_dispatcher_if #(
  parameter int array_size = 9,
  parameter int data_size  = 8,
  parameter int cnt_width  = 16
);
  logic [data_size-1:0]            in_data;
  logic                            in_valid;
  logic                            in_last;
  logic                            in_ready;
  logic [data_size*array_size-1:0] win_data;
  logic [1:0]                      win_sel;
  logic                            win_valid;
  logic                            win_last;
  logic [3:0]                      dest_ready;
  logic [cnt_width-1:0]            win_count;

  modport master (
    input  in_data, in_valid, in_last, dest_ready,
    output in_ready, win_data, win_sel, win_valid, win_last, win_count
  );

  modport slave (
    output in_data, in_valid, in_last, dest_ready,
    input  in_ready, win_data, win_sel, win_valid, win_last, win_count
  );
endinterface

// File: rtl/window_dispatcher.sv
// window_dispatcher
// Upstream stage of demux_array. Collects a serial stream of data_size-bit
// pixels into an array_size-element window, then issues the window with a
// 2-bit destination select to one of four PE groups, chosen round-robin.
// The window is held until the selected destination is ready. There is only
// one window buffer, so no pixels are accepted while a window is pending.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : window_dispatcher_if.master
//            in_data/in_valid/in_last/in_ready : pixel input handshake
//            win_data/win_sel/win_valid/win_last : issued window
//            dest_ready : per-destination ready, only dest_ready[win_sel] used
//            win_count  : windows transferred since reset (wraps)
module window_dispatcher #(
  parameter int array_size = 9,
  parameter int data_size  = 8,
  parameter int cnt_width  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  window_dispatcher_if.master  bus
);

  localparam int idx_w = (array_size > 1) ? $clog2(array_size + 1) : 1;

  typedef logic [idx_w-1:0] idx_t;
  typedef enum logic {FILL, ISSUE} state_t;

  localparam idx_t last_idx = idx_t'(array_size - 1);

  state_t                          state;
  idx_t                            idx;
  logic                            run;
  logic [data_size*array_size-1:0] win_data_q;
  logic [1:0]                      sel_q;
  logic                            valid_q;
  logic                            last_q;
  logic [cnt_width-1:0]            count_q;
  logic                            in_ready;
  logic                            accept;
  logic                            transfer;

  // run holds in_ready low while in reset and drops it only until the first
  // clock edge after release; beyond that in_ready is a pure state decode.
  assign in_ready = run && (state == FILL);
  assign accept   = bus.in_valid && in_ready;
  assign transfer = valid_q && bus.dest_ready[sel_q];

  // NOTE: every register here uses <= so that all of them see the pre-edge
  // values of each other; blocking = would make results order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      idx        <= '0;
      run        <= 1'b0;
      // NOTE: the window buffer is reset (not left undefined) because short
      // frames rely on the unwritten slots reading as zero.
      win_data_q <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      run <= 1'b1;
      unique case (state)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < array_size; k++) begin
              if (idx == idx_t'(k)) begin
                win_data_q[k*data_size +: data_size] <= bus.in_data;
              end
            end
            idx <= idx + idx_t'(1);
            // The window closes on the final slot or on an early frame end.
            if (idx == last_idx || bus.in_last) begin
              state   <= ISSUE;
              valid_q <= 1'b1;
              last_q  <= bus.in_last;
            end
          end
        end
        ISSUE: begin
          if (transfer) begin
            state      <= FILL;
            idx        <= '0;
            valid_q    <= 1'b0;
            win_data_q <= '0;
            count_q    <= count_q + cnt_width'(1);
            // A frame end restarts the round-robin at destination 0.
            sel_q      <= last_q ? 2'd0 : sel_q + 2'd1;
            last_q     <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.win_data  = win_data_q;
  assign bus.win_sel   = sel_q;
  assign bus.win_valid = valid_q;
  assign bus.win_last  = last_q;
  assign bus.win_count = count_q;

endmodule

// File: tb/tb_window_dispatcher.sv
// Directed testbench for window_dispatcher. Inputs are driven and outputs
// sampled 1 ns after the rising clock edge; expected values are hand-computed.
module tb_window_dispatcher;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  window_dispatcher_if #(.array_size(9), .data_size(8), .cnt_width(16)) bus ();

  window_dispatcher #(.array_size(9), .data_size(8), .cnt_width(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One element offered for exactly one clock edge.
  task automatic push(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic apply_reset();
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_data    = '0;
    bus.dest_ready = 4'hF;
    rst_n = 1'b0;
    #2;
    check("rst in_ready",  bus.in_ready,  1'b0);
    check("rst win_valid", bus.win_valid, 1'b0);
    check("rst win_data",  bus.win_data,  72'h0);
    check("rst win_sel",   bus.win_sel,   2'd0);
    check("rst win_last",  bus.win_last,  1'b0);
    check("rst win_count", bus.win_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-rst in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    int       early;
    int       valid_cnt;
    int       ready_low;
    logic [9:0] sels;
    logic [71:0] held;

    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_data    = '0;
    bus.dest_ready = 4'hF;
    #3;

    // Test 1: single full window.
    apply_reset();
    for (int i = 1; i <= 9; i++) push(8'(i), 1'b0);
    check("t1 win_valid", bus.win_valid, 1'b1);
    check("t1 win_data",  bus.win_data,  72'h090807060504030201);
    check("t1 win_sel",   bus.win_sel,   2'd0);
    check("t1 win_last",  bus.win_last,  1'b0);
    check("t1 in_ready",  bus.in_ready,  1'b0);
    tick();
    check("t1 pulse end", bus.win_valid, 1'b0);
    check("t1 win_count", bus.win_count, 16'd1);
    check("t1 data clr",  bus.win_data,  72'h0);
    check("t1 in_ready",  bus.in_ready,  1'b1);

    // Test 2: five back-to-back windows with in_valid held high.
    apply_reset();
    valid_cnt = 0;
    ready_low = 0;
    sels      = '0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      bus.in_data = 8'(c + 1);
      tick();
      if (bus.win_valid) begin
        valid_cnt++;
        sels = {sels[7:0], bus.win_sel};
      end
      if (!bus.in_ready) ready_low++;
    end
    bus.in_valid = 1'b0;
    check("t2 windows",   valid_cnt,     5);
    check("t2 sel seq",   sels,          10'b00_01_10_11_00);
    check("t2 ready low", ready_low,     5);
    check("t2 win_count", bus.win_count, 16'd5);

    // Test 3: stall on destination 0; pixels offered during the stall are refused.
    apply_reset();
    for (int i = 0; i < 9; i++) push(8'h11 + 8'(i), 1'b0);
    held = 72'h191817161514131211;
    bus.dest_ready = 4'b1110;
    check("t3 issue data", bus.win_data, held);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int s = 0; s < 6; s++) begin
      tick();
      check("t3 stall valid", bus.win_valid, 1'b1);
      check("t3 stall data",  bus.win_data,  held);
      check("t3 stall ready", bus.in_ready,  1'b0);
    end
    check("t3 stall count", bus.win_count, 16'd0);
    bus.dest_ready = 4'b0001;
    tick();
    bus.in_valid = 1'b0;
    check("t3 xfer valid", bus.win_valid, 1'b0);
    check("t3 xfer count", bus.win_count, 16'd1);
    check("t3 xfer sel",   bus.win_sel,   2'd1);
    check("t3 no accept",  bus.win_data,  72'h0);
    bus.dest_ready = 4'hF;

    // Test 4: short frame, in_last on the 4th element.
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b0);
    push(8'hA4, 1'b1);
    check("t4 win_valid", bus.win_valid, 1'b1);
    check("t4 win_data",  bus.win_data,  72'h00000000_00A4A3A2A1);
    check("t4 win_last",  bus.win_last,  1'b1);
    check("t4 win_sel",   bus.win_sel,   2'd1);
    tick();
    check("t4 sel reset", bus.win_sel,   2'd0);
    check("t4 last clr",  bus.win_last,  1'b0);
    check("t4 count",     bus.win_count, 16'd2);
    for (int i = 1; i <= 9; i++) push(8'(i), 1'b0);
    check("t4 next sel",  bus.win_sel,   2'd0);
    check("t4 next data", bus.win_data,  72'h090807060504030201);
    tick();

    // Test 5: in_valid toggled 1,0,0 per element.
    early = 0;
    for (int i = 1; i <= 9; i++) begin
      push(8'(i), 1'b0);
      if (i == 3) check("t5 partial", bus.win_data, 72'h030201);
      if (i < 9) begin
        repeat (2) begin
          tick();
          if (bus.win_valid) early++;
        end
      end
    end
    check("t5 early valid", early,         0);
    check("t5 win_valid",   bus.win_valid, 1'b1);
    check("t5 win_data",    bus.win_data,  72'h090807060504030201);
    check("t5 win_sel",     bus.win_sel,   2'd1);
    tick();
    check("t5 count",       bus.win_count, 16'd4);

    // Test 6: reset after 5 accepted elements discards the partial window.
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b0);
    #2;
    apply_reset();
    for (int i = 0; i < 9; i++) push(8'h31 + 8'(i), 1'b0);
    check("t6 win_valid", bus.win_valid, 1'b1);
    check("t6 win_data",  bus.win_data,  72'h393837363534333231);
    check("t6 win_sel",   bus.win_sel,   2'd0);
    tick();
    check("t6 count",     bus.win_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/window_dispatcher.md
Name: window_dispatcher

Overview:
- Upstream stage of demux_array.
- Accepts a serial stream of data_size-bit pixels with a valid/ready handshake. Assembles them into an array_size-element flat window and issues each window, with a 2-bit destination select, to the demux_array / 4 PE-group fabric.
- Destinations are served round-robin. The window is held until the selected destination signals ready.

Parameters:
- array_size, 9, elements per window (3x3 kernel).
- data_size, 8, bits per element.
- cnt_width, 16, width of the issued-window counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  data_size  incoming element.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks final element of a frame; qualified by in_valid.
- in_ready  output  1  block can accept an element this cycle.
- win_data  output  data_size*array_size  assembled window; element k at bits [(k+1)*data_size-1 : k*data_size].
- win_sel  output  2  destination index; drives demux_array sel.
- win_valid  output  1  win_data/win_sel valid.
- win_last  output  1  window closes a frame.
- dest_ready  input  4  per-destination ready; only dest_ready[win_sel] is used.
- win_count  output  cnt_width  number of windows transferred since reset, wraps.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state=FILL, element index idx=0, win_data=0, win_sel=0, win_valid=0, win_last=0, win_count=0.
  - in_ready=0 while rst_n low; in_ready=1 from the first clock edge after release.
- Registered outputs, except in_ready, which is decoded from state (1 in FILL, 0 in ISSUE).
- State FILL:
  - An element is accepted on in_valid & in_ready. It is written to slot idx, and idx increments.
  - If idx==array_size-1 or in_last=1 on the accepting cycle: next state ISSUE, win_valid=1 from the next cycle, and win_last=in_last.
  - On in_last with idx<array_size-1, the unwritten slots remain 0 (cleared on entry to FILL).
  - in_valid gaps are allowed: idx holds and no slot changes.
- State ISSUE:
  - in_ready=0; win_data, win_sel and win_last are held stable.
  - Transfer occurs on win_valid & dest_ready[win_sel].
  - On transfer, the next cycle sets:
    - win_valid=0, win_data=0, idx=0, state=FILL.
    - win_count=win_count+1 (mod 2^cnt_width).
    - win_sel=(win_sel+1) mod 4, or win_sel=0 if win_last was 1.
    - win_last=0.
  - The other dest_ready bits are ignored; no timeout, the block waits indefinitely.
- Latency: win_valid rises one cycle after the accepting edge of the window's final element. Minimum period is array_size+1 cycles per window with no back-pressure. The block does not accept during ISSUE (single buffer).
- in_last with idx==array_size-1 gives a full window with win_last=1.
- in_last on a lone first element gives a window with only slot 0 non-zero.
- in_valid with in_last=0 in ISSUE is ignored (not accepted, in_ready=0).
- Reset mid-fill or mid-issue discards the partial or pending window. The first window after reset uses win_sel=0.
- win_sel wraps 3->0 without gaps.

Test Plan:
- Reset, then in_data=1..9 on consecutive cycles, dest_ready=4'hF -> win_valid one cycle after the 9th, win_data=72'h090807060504030201, win_sel=0, win_last=0, one-cycle pulse, win_count=1.
- Five back-to-back full windows, dest_ready=4'hF -> win_sel sequence 0,1,2,3,0 and win_count=5; in_ready low exactly one cycle per window.
- Window with win_sel=0 and dest_ready=4'b1110 for 6 cycles, then 4'b0001 -> win_valid and win_data stable and in_ready=0 for 6 cycles; transfer on the 7th; in_data offered during the stall is not accepted.
- Elements 8'hA1,8'hA2,8'hA3,8'hA4 with in_last on the 4th -> win_data upper 5 bytes zero, low 32 bits 32'hA4A3A2A1, win_last=1; the following window uses win_sel=0.
- in_valid toggled 1,0,0,1,... across 9 elements -> window identical to the gap-free case; idx advances only on accepted cycles.
- rst_n low after 5 accepted elements, then 9 new elements -> all outputs 0 during reset; the new window contains only post-reset data, with win_sel=0 and win_count=1.
